// File: rtl/mult_pkg.sv
// mult_pkg: shared state type and Booth recode constants for the sequential multiplier
package mult_pkg;
  typedef enum logic {IDLE, RUN} mult_state_t;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth iteration (recode, add/sub into upper half, arithmetic shift)
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH+2:0] p,
  input  logic [WIDTH:0]     m,
  output logic [2*WIDTH+2:0] p_nxt
);
  logic [WIDTH:0] hi;
  logic [WIDTH:0] sum;
  assign hi = p[2*WIDTH+2:WIDTH+2];
  assign sum = p[1:0] == BOOTH_ADD ? hi + m : p[1:0] == BOOTH_SUB ? hi - m : hi;
  assign p_nxt = {sum[WIDTH], sum, p[WIDTH+1:1]};
endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential signed/unsigned radix-2 Booth multiplier with busy/done handshake
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             IsSigned,
  input  logic             MultIn,
  output logic             Busy,
  output logic             MultOut,
  output logic [WIDTH-1:0] resultHigh,
  output logic [WIDTH-1:0] resultLow
);
  mult_state_t state;
  logic [2*WIDTH+2:0] p;
  logic [2*WIDTH+2:0] p_nxt;
  logic [WIDTH:0] m;
  logic [CNT_W-1:0] cnt;
  booth_step #(.WIDTH(WIDTH)) u_step (.p(p), .m(m), .p_nxt(p_nxt));
  assign Busy = state == RUN;
  // capture operands on accept, iterate WIDTH+1 Booth steps, then publish the product
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
      p <= '0;
      m <= '0;
      cnt <= '0;
      MultOut <= 1'b0;
      resultHigh <= '0;
      resultLow <= '0;
    end else begin
      MultOut <= 1'b0;
      if (state == IDLE) begin
        if (MultIn) begin
          p <= {{(WIDTH+1){1'b0}}, IsSigned & B[WIDTH-1], B, 1'b0};
          m <= {IsSigned & A[WIDTH-1], A};
          cnt <= CNT_W'(WIDTH + 1);
          state <= RUN;
        end
      end else begin
        p <= p_nxt;
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          {resultHigh, resultLow} <= p_nxt[2*WIDTH:1];
          MultOut <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule
